pe_bf_pipe: RTL and testbench
=============================

// Module: pe_bf_pipe
// PURPOSE
//  Parametrised radix-2 butterfly processing element for the RFFT datapath; successor of the fixed 4-input PE.
//  LANES independent butterflies; each computes a+b and (a-b)*tf, the twiddled term optionally bypassed.
//  Adds signed arithmetic, rounding, saturation, per-sample scale-by-1/2, valid/ready flow control and a sticky overflow flag.
// PARAMETERS
//  WIDTH  32  sample and twiddle width, signed two's complement
//  SHIFT  16  twiddle fraction bits; product is right-shifted by SHIFT
//  LANES  2   butterflies per PE; 2*LANES input and output samples
//  ROUND  1   1: round-half-up on every right shift; 0: truncate (floor)
//  SAT    1   1: saturate to WIDTH; 0: wrap (keep low WIDTH bits)
// PORTS
//  Clk        in   1              clock, rising edge
//  Reset_n    in   1              synchronous active-low reset
//  in_valid   in   1              input sample set valid
//  in_ready   out  1              PE accepts the input this cycle
//  in_data    in   2*LANES*WIDTH  sample i = bits [i*WIDTH +: WIDTH]
//  tf         in   WIDTH          twiddle for this sample set, Q(SHIFT), shared by all lanes
//  bypass_n   in   1              1: multiply differences by tf; 0: pass differences through
//  scale      in   1              1: divide sums and differences by 2 (block-floating-point stage)
//  out_valid  out  1              output sample set valid
//  out_ready  in   1              downstream accepts the output
//  out_data   out  2*LANES*WIDTH  sums at slots 0..LANES-1; diffs at slots LANES..2*LANES-1
//  ovf        out  1              sticky: a saturation occurred
//  ovf_clr    in   1              clears ovf
// BEHAVIOUR
//  - Clk is the only clock. Reset_n is synchronous and active-low.
//  - Reset (Reset_n=0 at a rising edge): out_data=0, out_valid=0, ovf=0, all stage valids and registers cleared.
//    Reset mid-stream drops in-flight samples. in_ready=1 during reset.
//  - Lane k takes a=in[2k] and b=in[2k+1]. It drives out[k]=S_k and out[LANES+k]=D_k.
//  - Pipeline is three stages (S1, S2, S3). Latency is 3 cycles from accept to out_valid with no stall.
//    Throughput is one sample set per cycle.
//  - Flow control: en = !out_valid || out_ready; in_ready = en. An input is accepted when in_valid && en.
//    When en=0, all stages hold: out_data is stable and no sample is lost or duplicated. Order is preserved.
//    With en=1 and no input, a bubble (valid=0) enters S1.
//  - tf, bypass_n and scale are sampled on accept and travel with the data; changes mid-pipeline do not affect in-flight sets.
//  - S1: s=a+b and d=a-b, each WIDTH+1 bits.
//    If scale=1: s=(s+ROUND)>>>1 and d=(d+ROUND)>>>1.
//  - S2: p=d*tf, signed, 2*WIDTH+1 bits. s and d are delayed alongside.
//  - S3, twiddled path (bypass_n=1): D=(p + (ROUND ? 2^(SHIFT-1) : 0))>>>SHIFT, then reduced to WIDTH.
//    bypass_n=0: D = d reduced to WIDTH. S = s reduced to WIDTH.
//  - Reduction to WIDTH: SAT=1 clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. SAT=0 keeps the low WIDTH bits.
//  - ovf is set when any clamp actually changes a value in an S3 register load with valid=1 and en=1.
//    ovf_clr clears it. If set and clear occur in the same cycle, set wins.
//  - Bubbles never set ovf. ovf is never set when SAT=0.
// STRUCTURE
//  - pe_pkg holds the sat_signed(value, width) function and the out_data slot index localparams.
//  - One sub-module, pe_bf_lane: S1..S3 datapath for a single butterfly, instantiated LANES times by generate.
//    It has no control logic.
//  - Top level holds the valid shift chain, en, the sideband pipeline (tf, bypass_n, scale) and the ovf OR-reduction.
// TESTING (WIDTH=16, SHIFT=8, LANES=2 unless stated)
//  1 Basic: in={100,50,-20,30}, tf=128, bypass_n=1, scale=0 -> 3 cycles later out={150,10,25,-25}, ovf=0.
//  2 Round: a=3, b=0, tf=128 -> D=2 with ROUND=1; D=1 with ROUND=0. Bypass with a=3, b=0 -> D=3.
//  3 Saturate: a=32767, b=1 -> S=32767, ovf=1. Pulse ovf_clr -> ovf=0.
//    Simultaneous new overflow and ovf_clr -> ovf=1. Same stimulus with SAT=0 -> S=-32768, ovf=0.
//  4 Scale: a=32767, b=1, scale=1 -> S=16384, D=16383 (bypass), ovf=0.
//    Changing scale in the cycle after accept leaves that set unaffected.
//  5 Backpressure: stream 8 sets with out_ready=0 for 5 cycles.
//    in_ready falls once the pipeline fills; out_data is held stable. All 8 sets emerge in order, none duplicated.
//  6 Reset: assert Reset_n=0 for 1 cycle with 3 sets in flight.
//    Next cycle out_valid=0, out_data=0, ovf=0; no stale set ever appears.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the radix-2 butterfly PE.
//   MAXW              width of the working type used by sat_signed
//   A_OFS / B_OFS     position of a and b inside a lane's input pair
//   SUM_BASE          first out_data slot holding a sum; diffs follow at LANES
//   sat_signed()      clamps a signed value to the range of a 'width'-bit signed
package pe_pkg;

   localparam int unsigned MAXW     = 128;
   localparam int unsigned A_OFS    = 0;
   localparam int unsigned B_OFS    = 1;
   localparam int unsigned SUM_BASE = 0;

   function automatic logic signed [MAXW-1:0] sat_signed(
      input logic signed [MAXW-1:0] value,
      input int unsigned            width
   );
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      hi = (MAXW'(1) << (width - 1)) - MAXW'(1);
      lo = ~hi;
      if (value > hi)      return hi;
      else if (value < lo) return lo;
      else                 return value;
   endfunction

endpackage

// File: rtl/pe_bf_lane.sv
// pe_bf_lane: S1..S3 datapath of one butterfly, no flow control of its own.
//   clk, rst_n    clock, synchronous active-low reset
//   en            advance all three stages
//   a, b          input pair (S1 input)
//   scale         halve sum and difference in S1
//   tf_s1         twiddle belonging to the set currently held in S1
//   bypass_n_s2   twiddle select belonging to the set currently held in S2
//   sum, diff     S3 registers
//   clamp         the value about to be loaded into S3 is being clamped
module pe_bf_lane
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHIFT = 16,
   parameter int unsigned ROUND = 1,
   parameter int unsigned SAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  logic                    scale,
   input  logic signed [WIDTH-1:0] tf_s1,
   input  logic                    bypass_n_s2,
   output logic signed [WIDTH-1:0] sum,
   output logic signed [WIDTH-1:0] diff,
   output logic                    clamp
);

   localparam int unsigned PW = 2*WIDTH + 2;
   localparam logic signed [WIDTH+1:0] RND1   = (ROUND != 0) ? (WIDTH+2)'(1) : '0;
   localparam logic signed [PW-1:0]    RND_TW = (ROUND != 0) ? (PW'(1) << (SHIFT - 1)) : '0;

   logic signed [WIDTH+1:0] s_ext, d_ext;
   logic signed [WIDTH:0]   s1_nxt, d1_nxt, s1, d1, s2, d2;
   logic signed [PW-1:0]    p_nxt, p2, d_pre, s_pre;
   logic signed [WIDTH-1:0] sum_nxt, diff_nxt;
   logic                    clamp_s, clamp_d;

   always_comb begin
      // two guard bits: a-b plus the rounding constant can need WIDTH+2 bits
      s_ext = (WIDTH+2)'(a) + (WIDTH+2)'(b);
      d_ext = (WIDTH+2)'(a) - (WIDTH+2)'(b);
      if (scale) begin
         s1_nxt = (WIDTH+1)'((s_ext + RND1) >>> 1);
         d1_nxt = (WIDTH+1)'((d_ext + RND1) >>> 1);
      end else begin
         s1_nxt = (WIDTH+1)'(s_ext);
         d1_nxt = (WIDTH+1)'(d_ext);
      end

      p_nxt = PW'(d1) * PW'(tf_s1);

      d_pre = bypass_n_s2 ? ((p2 + RND_TW) >>> SHIFT) : PW'(d2);
      s_pre = PW'(s2);

      if (SAT != 0) begin
         sum_nxt  = WIDTH'(sat_signed(MAXW'(s_pre), WIDTH));
         diff_nxt = WIDTH'(sat_signed(MAXW'(d_pre), WIDTH));
         clamp_s  = sat_signed(MAXW'(s_pre), WIDTH) != MAXW'(s_pre);
         clamp_d  = sat_signed(MAXW'(d_pre), WIDTH) != MAXW'(d_pre);
      end else begin
         sum_nxt  = WIDTH'(s_pre);
         diff_nxt = WIDTH'(d_pre);
         clamp_s  = 1'b0;
         clamp_d  = 1'b0;
      end
      clamp = clamp_s | clamp_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= '0;
         d1   <= '0;
         s2   <= '0;
         d2   <= '0;
         p2   <= '0;
         sum  <= '0;
         diff <= '0;
      end else if (en) begin
         s1   <= s1_nxt;
         d1   <= d1_nxt;
         s2   <= s1;
         d2   <= d1;
         p2   <= p_nxt;
         sum  <= sum_nxt;
         diff <= diff_nxt;
      end
   end

endmodule

// File: rtl/pe_bf_pipe.sv
// pe_bf_pipe: LANES radix-2 butterflies in a 3-stage valid/ready pipeline.
//   Clk, Reset_n         clock, synchronous active-low reset
//   in_valid/in_ready    input handshake; in_data holds 2*LANES samples
//   tf, bypass_n, scale  per-set sideband, captured on accept
//   out_valid/out_ready  output handshake; out_data = sums then diffs
//   ovf, ovf_clr         sticky saturation flag and its clear
module pe_bf_pipe
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHIFT = 16,
   parameter int unsigned LANES = 2,
   parameter int unsigned ROUND = 1,
   parameter int unsigned SAT   = 1
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2*LANES*WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0]         tf,
   input  logic                     bypass_n,
   input  logic                     scale,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*LANES*WIDTH-1:0] out_data,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   logic                    en;
   logic                    v1, v2;
   logic [WIDTH-1:0]        tf_s1;
   logic                    byp_s1, byp_s2;
   logic signed [WIDTH-1:0] sum_w  [LANES];
   logic signed [WIDTH-1:0] diff_w [LANES];
   logic [LANES-1:0]        clamp_w;

   assign en       = !out_valid || out_ready;
   assign in_ready = en || !Reset_n;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         tf_s1     <= '0;
         byp_s1    <= 1'b0;
         byp_s2    <= 1'b0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         tf_s1     <= tf;
         byp_s1    <= bypass_n;
         byp_s2    <= byp_s1;
      end
   end

   // a fresh overflow takes priority over a clear in the same cycle
   always_ff @(posedge Clk) begin
      if (!Reset_n)                      ovf <= 1'b0;
      else if (en && v2 && (|clamp_w))   ovf <= 1'b1;
      else if (ovf_clr)                  ovf <= 1'b0;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      pe_bf_lane #(
         .WIDTH (WIDTH),
         .SHIFT (SHIFT),
         .ROUND (ROUND),
         .SAT   (SAT)
      ) u_lane (
         .clk         (Clk),
         .rst_n       (Reset_n),
         .en          (en),
         .a           (in_data[(2*k+A_OFS)*WIDTH +: WIDTH]),
         .b           (in_data[(2*k+B_OFS)*WIDTH +: WIDTH]),
         .scale       (scale),
         .tf_s1       (tf_s1),
         .bypass_n_s2 (byp_s2),
         .sum         (sum_w[k]),
         .diff        (diff_w[k]),
         .clamp       (clamp_w[k])
      );
   end

   always_comb begin
      out_data = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         out_data[(SUM_BASE+k)*WIDTH +: WIDTH] = sum_w[k];
         out_data[(LANES+k)*WIDTH +: WIDTH]    = diff_w[k];
      end
   end

endmodule

// File: tb/tb_pe_bf_pipe.sv
module tb_pe_bf_pipe;

   localparam int unsigned W  = 16;
   localparam int unsigned SH = 8;
   localparam int unsigned L  = 2;

   typedef struct {
      int a0, b0, a1, b1, tf;
      bit byp, sc;
   } tset_t;

   logic           Clk = 1'b0;
   logic           Reset_n, in_valid, out_ready, bypass_n, scale, ovf_clr;
   logic [63:0]    in_data;
   logic [15:0]    tf;
   logic           in_ready, out_valid, ovf;
   logic [63:0]    out_data;
   logic           in_ready_r0, out_valid_r0, ovf_r0;
   logic [63:0]    out_data_r0;
   logic           in_ready_s0, out_valid_s0, ovf_s0;
   logic [63:0]    out_data_s0;

   int    checks = 0;
   int    errors = 0;
   int    pops   = 0;
   bit    run    = 0;
   bit    hold_pending = 0;
   logic [63:0] held;
   tset_t cur;
   tset_t q[$];

   always #5 Clk = ~Clk;

   pe_bf_pipe #(.WIDTH(W), .SHIFT(SH), .LANES(L), .ROUND(1), .SAT(1)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .tf(tf), .bypass_n(bypass_n), .scale(scale),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ovf(ovf), .ovf_clr(ovf_clr));

   pe_bf_pipe #(.WIDTH(W), .SHIFT(SH), .LANES(L), .ROUND(0), .SAT(1)) dut_r0 (
      .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready_r0),
      .in_data(in_data), .tf(tf), .bypass_n(bypass_n), .scale(scale),
      .out_valid(out_valid_r0), .out_ready(out_ready), .out_data(out_data_r0),
      .ovf(ovf_r0), .ovf_clr(ovf_clr));

   pe_bf_pipe #(.WIDTH(W), .SHIFT(SH), .LANES(L), .ROUND(1), .SAT(0)) dut_s0 (
      .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready_s0),
      .in_data(in_data), .tf(tf), .bypass_n(bypass_n), .scale(scale),
      .out_valid(out_valid_s0), .out_ready(out_ready), .out_data(out_data_s0),
      .ovf(ovf_s0), .ovf_clr(ovf_clr));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] reduce(input longint x, input int sat);
      longint y;
      y = x;
      if (sat != 0) begin
         if (y > 32767)  y = 32767;
         if (y < -32768) y = -32768;
      end
      return 16'(y);
   endfunction

   // Butterfly results straight from the arithmetic definition.
   function automatic logic [63:0] model(input tset_t t, input int rnd, input int sat);
      longint      a [2];
      longint      b [2];
      logic [15:0] s [2];
      logic [15:0] d [2];
      longint      sv, dv;
      a[0] = t.a0; b[0] = t.b0; a[1] = t.a1; b[1] = t.b1;
      for (int k = 0; k < 2; k++) begin
         sv = a[k] + b[k];
         dv = a[k] - b[k];
         if (t.sc) begin
            sv = (sv + rnd) >>> 1;
            dv = (dv + rnd) >>> 1;
         end
         if (t.byp)
            dv = (dv * t.tf + ((rnd != 0) ? (longint'(1) << (SH - 1)) : 0)) >>> SH;
         s[k] = reduce(sv, sat);
         d[k] = reduce(dv, sat);
      end
      return {d[1], d[0], s[1], s[0]};
   endfunction

   function automatic longint slot(input logic [63:0] v, input int i);
      logic signed [15:0] t;
      t = v[i*16 +: 16];
      return longint'(t);
   endfunction

   task automatic set_in(input int a0, b0, a1, b1, t, input bit byp, sc);
      cur.a0 = a0; cur.b0 = b0; cur.a1 = a1; cur.b1 = b1; cur.tf = t;
      cur.byp = byp; cur.sc = sc;
      in_data  = {16'(b1), 16'(a1), 16'(b0), 16'(a0)};
      tf       = 16'(t);
      bypass_n = byp;
      scale    = sc;
   endtask

   // Compare process: handshake rule, hold stability, scoreboard against the model.
   always @(negedge Clk) begin
      if (run) begin
         if (Reset_n) chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
         else         chk("in_ready_in_reset", 64'(in_ready), 64'd1);
         if (hold_pending) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, held);
         end
         chk("ovf_never_when_wrap", 64'(ovf_s0), 64'd0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
               tset_t t;
               t = q.pop_front();
               chk("sb_data_r1s1", out_data,    model(t, 1, 1));
               chk("sb_data_r0s1", out_data_r0, model(t, 0, 1));
               chk("sb_data_r1s0", out_data_s0, model(t, 1, 0));
               pops++;
            end
         end
         hold_pending = Reset_n && out_valid && !out_ready;
         held         = out_data;
         if (!Reset_n)                   q.delete();
         else if (in_valid && in_ready)  q.push_back(cur);
      end
   end

   task automatic send_one(input int a0, b0, a1, b1, t, input bit byp, sc, input bit flip);
      int lat;
      @(posedge Clk); #1;
      set_in(a0, b0, a1, b1, t, byp, sc);
      in_valid = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      if (flip) begin
         scale    = ~sc;
         bypass_n = ~byp;
         tf       = '0;
      end
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge Clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'd3);
   endtask

   initial begin
      int i, cyc, pops0, seen;
      bit saw_stall;
      Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      set_in(0, 0, 0, 0, 0, 1'b0, 1'b0);
      @(posedge Clk); #1;
      run = 1;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_data", out_data, 64'd0);
      chk("reset_ovf", 64'(ovf), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      // basic butterfly
      send_one(100, 50, -20, 30, 128, 1'b1, 1'b0, 1'b0);
      chk("basic_s0", 64'(slot(out_data, 0)), 64'(150));
      chk("basic_s1", 64'(slot(out_data, 1)), 64'(10));
      chk("basic_d0", 64'(slot(out_data, 2)), 64'(25));
      chk("basic_d1", 64'(slot(out_data, 3)), 64'(-25));
      chk("basic_ovf", 64'(ovf), 64'd0);

      // rounding vs truncation, and bypass
      send_one(3, 0, 0, 0, 128, 1'b1, 1'b0, 1'b0);
      chk("round_d0_r1", 64'(slot(out_data, 2)), 64'(2));
      chk("round_d0_r0", 64'(slot(out_data_r0, 2)), 64'(1));
      send_one(3, 0, 0, 0, 128, 1'b0, 1'b0, 1'b0);
      chk("bypass_d0", 64'(slot(out_data, 2)), 64'(3));

      // saturation and sticky flag
      send_one(32767, 1, 0, 0, 128, 1'b1, 1'b0, 1'b0);
      chk("sat_s0", 64'(slot(out_data, 0)), 64'(32767));
      chk("sat_d0", 64'(slot(out_data, 2)), 64'(16383));
      chk("sat_ovf", 64'(ovf), 64'd1);
      chk("wrap_s0", 64'(slot(out_data_s0, 0)), 64'(-32768));
      chk("wrap_ovf", 64'(ovf_s0), 64'd0);
      @(posedge Clk); #1 ovf_clr = 1'b1;
      @(posedge Clk); #1 ovf_clr = 1'b0;
      chk("ovf_cleared", 64'(ovf), 64'd0);
      @(posedge Clk); #1;
      set_in(32767, 1, 0, 0, 128, 1'b1, 1'b0);
      in_valid = 1'b1;
      @(posedge Clk); #1 in_valid = 1'b0;
      @(posedge Clk); #1 ovf_clr = 1'b1;
      @(posedge Clk); #1 ovf_clr = 1'b0;
      chk("set_vs_clr_valid", 64'(out_valid), 64'd1);
      chk("set_wins_over_clr", 64'(ovf), 64'd1);
      @(posedge Clk); #1 ovf_clr = 1'b1;
      @(posedge Clk); #1 ovf_clr = 1'b0;

      // scale, with sideband changed right after accept
      send_one(32767, 1, 0, 0, 128, 1'b0, 1'b1, 1'b1);
      chk("scale_s0", 64'(slot(out_data, 0)), 64'(16384));
      chk("scale_d0", 64'(slot(out_data, 2)), 64'(16383));
      chk("scale_ovf", 64'(ovf), 64'd0);

      // backpressure: out_ready low for 5 cycles while streaming 8 sets
      @(posedge Clk); #1;
      i = 0; cyc = 0; saw_stall = 0; pops0 = pops;
      while (i < 8 && cyc < 60) begin
         if (cyc != 0) begin
            @(posedge Clk); #1;
         end
         out_ready = !(cyc >= 2 && cyc < 7);
         set_in(i*1000 - 3000, 1234 - i*321, -i*77, i*55 + 7, i*37 - 100, i[0], i[1]);
         in_valid = 1'b1;
         @(negedge Clk);
         if (!in_ready) saw_stall = 1;
         else           i++;
         cyc++;
      end
      @(posedge Clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (pops != pops0 + 8 && cyc < 20) begin
         @(posedge Clk); #1;
         cyc++;
      end
      chk("bp_accepted", 64'(i), 64'd8);
      chk("bp_stall_seen", 64'(saw_stall), 64'd1);
      chk("bp_emerged", 64'(pops - pops0), 64'd8);

      // reset with three saturating sets in flight
      @(posedge Clk); #1;
      set_in(32767, 1, 1, 1, 128, 1'b1, 1'b0); in_valid = 1'b1;
      @(posedge Clk); #1;
      set_in(32767, 2, 2, 2, 128, 1'b1, 1'b0);
      @(posedge Clk); #1;
      set_in(32767, 3, 3, 3, 128, 1'b1, 1'b0);
      @(posedge Clk); #1;
      in_valid = 1'b0;
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      chk("pre_reset_ovf", 64'(ovf), 64'd1);
      Reset_n = 1'b0;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
      chk("mid_reset_out_data", out_data, 64'd0);
      chk("mid_reset_ovf", 64'(ovf), 64'd0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge Clk); #1;
         if (out_valid) seen++;
      end
      chk("no_stale_after_reset", 64'(seen), 64'd0);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
